// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the ARM pipeline memory arbiter.
package arm_mem_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_STARVE_MAX  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around the arbiter.
// The arbiter uses the slave view; the pipeline/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = arm_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = arm_mem_pkg::DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              freeze;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              protocol_err;

  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_en, sram_we, sram_addr, sram_wdata, protocol_err
  );

  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_en, sram_we, sram_addr, sram_wdata, protocol_err
  );

endinterface

// File: rtl/mem_grant_sel.sv
// Chooses which requester owns the next memory access. Data normally wins,
// but a fetch that has watched STARVE_MAX data grants go by gets the port.
module mem_grant_sel
  import arm_mem_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   data_req,
  input  logic   grant_en,
  output owner_t owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_d;
  logic [SW-1:0] starve_q;

  // Priority: data first unless the waiting fetch has been starved too long.
  always_comb begin
    owner = OWN_IF;
    if (data_req && !(if_req && (starve_q == STARVE_LIM))) begin
      owner = OWN_DATA;
    end
  end

  // Count data grants that overtook a waiting fetch; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!if_req) begin
      starve_d = '0;
    end else if (grant_en) begin
      if (owner == OWN_IF) begin
        starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one word-wide memory port between
// instruction fetch and MEM-stage data, holding the port for WAIT_CYCLES
// per access and answering with a one-cycle ready pulse.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q;
  owner_t            owner_q;
  owner_t            owner;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic              sram_en_q;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;

  logic              if_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              mem_ready_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              protocol_err_q;

  logic              data_req;
  logic              any_req;
  logic              grant_en;

  assign data_req = bus.mem_r_en | bus.mem_w_en;
  assign any_req  = bus.if_req | data_req;
  assign grant_en = (state_q == IDLE) && any_req;

  mem_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant_sel (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .data_req (data_req),
    .grant_en (grant_en),
    .owner    (owner)
  );

  // Access sequencer: latch the winner in IDLE, hold the port through BUSY,
  // then present the captured word with a single ready pulse in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      wait_cnt_q     <= '0;
      sram_en_q      <= 1'b0;
      sram_we_q      <= 1'b0;
      sram_addr_q    <= '0;
      sram_wdata_q   <= '0;
      if_ready_q     <= 1'b0;
      if_rdata_q     <= '0;
      mem_ready_q    <= 1'b0;
      mem_rdata_q    <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      if ((state_q == IDLE) && bus.mem_r_en && bus.mem_w_en) begin
        protocol_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q    <= owner;
            wait_cnt_q <= WAIT_LOAD;
            sram_en_q  <= 1'b1;
            if (owner == OWN_DATA) begin
              sram_addr_q  <= bus.mem_addr;
              sram_wdata_q <= bus.mem_wdata;
              sram_we_q    <= bus.mem_w_en;
            end else begin
              sram_addr_q  <= bus.if_addr;
              sram_wdata_q <= '0;
              sram_we_q    <= 1'b0;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt_q == '0) begin
            if (owner_q == OWN_IF) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.sram_rdata;
            end else begin
              mem_ready_q <= 1'b1;
              mem_rdata_q <= sram_we_q ? '0 : bus.sram_rdata;
            end
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sram_en      = sram_en_q;
  assign bus.sram_we      = sram_we_q;
  assign bus.sram_addr    = sram_addr_q;
  assign bus.sram_wdata   = sram_wdata_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.mem_ready    = mem_ready_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.protocol_err = protocol_err_q;

  assign bus.freeze = (bus.if_req & ~if_ready_q) | (data_req & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized requester phase, all compared against a timing-level model.
module tb_mem_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 2;
  localparam int STARVE_MAX  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Model: m_t is elapsed cycles since the grant (0 = free to grant).
  int          m_t;
  logic        m_own_data;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_cap;
  int          m_starve;
  logic        m_perr;
  logic        exp_if_done;
  logic        exp_d_done;

  int ready_log[$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES),
    .STARVE_MAX  (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic rd,
                               input logic wr, input logic [31:0] ma, input logic [31:0] wd,
                               input logic [31:0] srd);
    bus.if_req     = ifr;
    bus.if_addr    = ifa;
    bus.mem_r_en   = rd;
    bus.mem_w_en   = wr;
    bus.mem_addr   = ma;
    bus.mem_wdata  = wd;
    bus.sram_rdata = srd;
  endtask

  task automatic modelReset();
    m_t = 0; m_own_data = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    m_cap = '0; m_starve = 0; m_perr = 1'b0;
  endtask

  // Compare every output against what the model predicts for this cycle.
  task automatic checkAll();
    logic en, resp, e_ifr, e_mr, e_frz;
    en    = (m_t >= 1) && (m_t <= WAIT_CYCLES);
    resp  = (m_t == WAIT_CYCLES + 1);
    e_ifr = resp && !m_own_data;
    e_mr  = resp && m_own_data;
    e_frz = (bus.if_req & ~e_ifr) | ((bus.mem_r_en | bus.mem_w_en) & ~e_mr);
    checkOutput("sram_en", {63'd0, bus.sram_en}, {63'd0, en});
    checkOutput("sram_we", {63'd0, bus.sram_we}, {63'd0, en & m_we});
    checkOutput("sram_addr", {32'd0, bus.sram_addr}, {32'd0, en ? m_addr : 32'd0});
    if (en && m_we) checkOutput("sram_wdata", {32'd0, bus.sram_wdata}, {32'd0, m_wdata});
    checkOutput("if_ready", {63'd0, bus.if_ready}, {63'd0, e_ifr});
    checkOutput("if_rdata", {32'd0, bus.if_rdata}, {32'd0, e_ifr ? m_cap : 32'd0});
    checkOutput("mem_ready", {63'd0, bus.mem_ready}, {63'd0, e_mr});
    checkOutput("mem_rdata", {32'd0, bus.mem_rdata}, {32'd0, (e_mr && !m_we) ? m_cap : 32'd0});
    checkOutput("freeze", {63'd0, bus.freeze}, {63'd0, e_frz});
    checkOutput("protocol_err", {63'd0, bus.protocol_err}, {63'd0, m_perr});
    if (bus.if_ready === 1'b1) ready_log.push_back(0);
    if (bus.mem_ready === 1'b1) ready_log.push_back(1);
    exp_if_done = e_ifr;
    exp_d_done  = e_mr;
  endtask

  // Advance the model across one rising edge using the sampled inputs.
  task automatic modelEdge();
    logic ifr, dr, gd;
    if (!rst) begin
      modelReset();
      return;
    end
    ifr = bus.if_req;
    dr  = bus.mem_r_en | bus.mem_w_en;
    if (m_t == 0) begin
      if (bus.mem_r_en && bus.mem_w_en) m_perr = 1'b1;
      if (ifr || dr) begin
        gd = dr && !(ifr && (m_starve == STARVE_MAX));
        m_own_data = gd;
        m_addr  = gd ? bus.mem_addr : bus.if_addr;
        m_we    = gd && bus.mem_w_en;
        m_wdata = bus.mem_wdata;
        m_t     = 1;
        if (ifr) m_starve = gd ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      end
    end else if (m_t <= WAIT_CYCLES) begin
      if (m_t == WAIT_CYCLES) m_cap = bus.sram_rdata;
      m_t++;
    end else begin
      m_t = 0;
    end
    if (!ifr) m_starve = 0;
  endtask

  task automatic sampleNeg();
    @(negedge clk);
    checkAll();
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    int exp_seq[6];
    logic        f_act, d_act, d_rd, d_wr;
    logic [31:0] f_addr, d_addr, d_wdata;
    int          pick;

    modelReset();
    exp_if_done = 1'b0;
    exp_d_done  = 1'b0;

    // Reset held with both requesters active.
    rst = 1'b0;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, $urandom);
    for (int c = 0; c < 2; c++) begin
      sampleNeg();
      checkOutput("rst_freeze", {63'd0, bus.freeze}, 64'd1);
      checkOutput("rst_sram_en", {63'd0, bus.sram_en}, 64'd0);
      advance();
    end

    // Release with fetch and data both pending: data first, fetch after.
    rst = 1'b1;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c <= 7, 32'h10, c <= 3, 1'b0, 32'h40, 32'h0, $urandom);
      sampleNeg();
      if (c == 3) checkOutput("coll_data_ready", {63'd0, bus.mem_ready}, 64'd1);
      if (c == 6) checkOutput("coll_freeze_c6", {63'd0, bus.freeze}, 64'd1);
      if (c == 7) begin
        checkOutput("coll_fetch_ready", {63'd0, bus.if_ready}, 64'd1);
        checkOutput("coll_freeze_c7", {63'd0, bus.freeze}, 64'd0);
      end
      advance();
    end

    // Single fetch read.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c <= 3, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'hE3A01005);
      sampleNeg();
      if (c == 0) checkOutput("fetch_en_c0", {63'd0, bus.sram_en}, 64'd0);
      if (c == 1 || c == 2) begin
        checkOutput("fetch_en_busy", {63'd0, bus.sram_en}, 64'd1);
        checkOutput("fetch_addr", {32'd0, bus.sram_addr}, 64'h10);
      end
      if (c == 3) begin
        checkOutput("fetch_ready", {63'd0, bus.if_ready}, 64'd1);
        checkOutput("fetch_rdata", {32'd0, bus.if_rdata}, 64'hE3A01005);
      end
      if (c == 4) checkOutput("fetch_ready_gone", {63'd0, bus.if_ready}, 64'd0);
      advance();
    end

    // Starvation: both held back-to-back for six grants.
    ready_log.delete();
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, $urandom);
      sampleNeg();
      advance();
    end
    exp_seq = '{1, 1, 1, 1, 0, 1};
    checkOutput("starve_count", 64'(ready_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("starve_grant", (i < ready_log.size()) ? 64'(ready_log[i]) : 64'd2, 64'(exp_seq[i]));
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
      sampleNeg();
      advance();
    end

    // Data write.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, c <= 3, 32'h20, 32'hDEADBEEF, $urandom);
      sampleNeg();
      if (c == 1 || c == 2) begin
        checkOutput("wr_we", {63'd0, bus.sram_we}, 64'd1);
        checkOutput("wr_addr", {32'd0, bus.sram_addr}, 64'h20);
        checkOutput("wr_wdata", {32'd0, bus.sram_wdata}, 64'hDEADBEEF);
      end
      if (c == 3) begin
        checkOutput("wr_ready", {63'd0, bus.mem_ready}, 64'd1);
        checkOutput("wr_rdata", {32'd0, bus.mem_rdata}, 64'd0);
        checkOutput("wr_perr", {63'd0, bus.protocol_err}, 64'd0);
      end
      advance();
    end

    // Read and write together: write wins, error latches.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 32'h0, c <= 3, c <= 3, 32'h24, 32'h12345678, $urandom);
      sampleNeg();
      if (c == 1) checkOutput("rw_we", {63'd0, bus.sram_we}, 64'd1);
      if (c == 1 || c == 7) checkOutput("rw_perr", {63'd0, bus.protocol_err}, 64'd1);
      advance();
    end

    // Reset in the second BUSY cycle, then rerun with the request held.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
      if (c == 2) begin
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_mid_en", {63'd0, bus.sram_en}, 64'd0);
        checkOutput("rst_mid_perr", {63'd0, bus.protocol_err}, 64'd0);
      end
      sampleNeg();
      if (c >= 2) checkOutput("rst_mid_noready", {63'd0, bus.if_ready}, 64'd0);
      advance();
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c <= 3, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
      sampleNeg();
      if (c == 1) checkOutput("rerun_addr", {32'd0, bus.sram_addr}, 64'h30);
      if (c == 3) checkOutput("rerun_ready", {63'd0, bus.if_ready}, 64'd1);
      advance();
    end

    // Randomized requesters obeying the hold-until-ready protocol.
    f_act = 1'b0; d_act = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      if (f_act) begin
        if (exp_if_done) begin
          f_act  = ($urandom_range(99) < 60);
          f_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(99) < 35) begin
        f_act  = 1'b1;
        f_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_act ? exp_d_done : ($urandom_range(99) < 40)) begin
        d_act   = d_act ? ($urandom_range(99) < 60) : 1'b1;
        pick    = $urandom_range(99);
        d_rd    = (pick < 50) || (pick >= 97);
        d_wr    = (pick >= 50);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end
      applyStimulus(f_act, (m_t == 0) ? f_addr : $urandom,
                    d_act && d_rd, d_act && d_wr,
                    (m_t == 0) ? d_addr : $urandom,
                    (m_t == 0) ? d_wdata : $urandom, $urandom);
      sampleNeg();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the ARM pipeline. It shares one word-wide memory port between the instruction-fetch requester and the MEM-stage data requester, and drives that port for a fixed number of wait cycles per access. It returns read data with a one-cycle ready pulse and raises a pipeline freeze while any request is outstanding. It sits between the IF/MEM stages and the unified memory.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width
- `WAIT_CYCLES`, 2, cycles the memory port is held per access (≥1)
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch read request; held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch data; valid only while `if_ready`, else 0
- `if_ready`  out  1  one-cycle completion pulse
- `mem_r_en`, `mem_w_en`  in  1  data read/write request; held until `mem_ready`
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  write data
- `mem_rdata`  out  DATA_W  read data; valid only while `mem_ready` on a read, else 0
- `mem_ready`  out  1  one-cycle completion pulse
- `freeze`  out  1  combinational: `(if_req & ~if_ready) | ((mem_r_en|mem_w_en) & ~mem_ready)`
- `sram_en`, `sram_we`  out  1  memory port enable/write enable
- `sram_addr`  out  ADDR_W  memory address (byte address, passed through unmodified)
- `sram_wdata`  out  DATA_W  memory write data
- `sram_rdata`  in  DATA_W  memory read data, sampled on the last BUSY cycle
- `protocol_err`  out  1  sticky; set when `mem_r_en & mem_w_en` is sampled in IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**, no request: stay.
- **IDLE**, any request:
  - Select the owner.
  - Latch addr, wdata, we and owner.
  - Load the wait counter with WAIT_CYCLES-1.
  - Go to BUSY.
- **BUSY**:
  - `sram_en`=1, and `sram_addr`/`sram_wdata`/`sram_we` come from the latches.
  - Counter decrements each cycle.
  - At counter 0, capture `sram_rdata` into the response register and go to RESP.
- **RESP**:
  - Pulse the owner's ready.
  - Drive the rdata output for a read, or 0 for a write.
  - Go to IDLE.
- **Priority**: data beats fetch, except when the starvation counter equals STARVE_MAX. In that case fetch is granted.
- **Starvation counter**:
  - Increments on each data grant made while `if_req`=1.
  - Clears on a fetch grant, or in any cycle where `if_req`=0.
  - Saturates at STARVE_MAX.
- **Read and write both asserted**: the write wins and `protocol_err` is set. Only reset clears `protocol_err`.
- **Requester protocol**: in the cycle after its ready, the requester presents its next request or drops its request. A request still high in IDLE is a new access.
- **Request changes during BUSY** are ignored, because the latched values are used.

## Timing
- **Reset** (`rst`=0, asynchronous):
  - State goes to IDLE and all registered outputs go to 0: `if_ready`, `mem_ready`, rdata outputs, `sram_*`, `protocol_err`.
  - Counters clear.
  - The in-flight access is abandoned. For an aborted write, memory contents at that address are undefined.
- **Latency**:
  - Request sampled in IDLE at cycle 0.
  - BUSY for cycles 1..WAIT_CYCLES.
  - Ready at cycle WAIT_CYCLES+1.
- **Throughput**: one access per WAIT_CYCLES+2 cycles.
- **Simultaneous fetch and data** in IDLE: one is granted. The other keeps `freeze`=1 and is granted in the next IDLE cycle.
- **`freeze`** is combinational from the inputs and the ready outputs. It is 0 during the ready cycle when that was the only request.

## Structure
- Package `arm_mem_pkg`:
  - State enum (IDLE/BUSY/RESP).
  - Owner enum (OWN_IF/OWN_DATA).
  - Default widths.
- Sub-module `mem_grant_sel`: combinational priority plus the registered starvation counter. Outputs the owner for the current cycle.
- Top level holds the FSM, wait counter, latches and response register.

## Test plan
- **Reset**: hold `rst`=0 with requests active → all outputs 0 and `freeze` reflects the requests. Release → the first grant starts on the next edge.
- **Fetch read**, WAIT_CYCLES=2: `if_addr`=0x10, `sram_rdata`=0xE3A01005 → `sram_en` high for cycles 1–2, and `if_ready`=1 with `if_rdata`=0xE3A01005 at cycle 3 only.
- **Collision**: `if_req` and `mem_r_en` in the same cycle → the data access completes at cycle 3 and the fetch access at cycle 7. `freeze` stays 1 until cycle 7.
- **Starvation**, STARVE_MAX=4: data reads back-to-back with `if_req` held → grants 1–4 go to data, grant 5 goes to fetch, grant 6 goes to data.
- **Write**: `mem_w_en`, addr 0x20, wdata 0xDEADBEEF → `sram_we`=1 with those values for 2 cycles, then a `mem_ready` pulse with `mem_rdata`=0. With `mem_r_en` also high, `protocol_err`=1 and stays 1.
- **Reset mid-access**: assert `rst` in the second BUSY cycle → `sram_en` drops to 0 immediately and no ready pulse occurs. After release with the request still held, a full access reruns.
